// File: rtl/beam_sum_accumulator.sv
// Delay-and-sum output stage: captures one NUM_CH-sample vector, sums it one channel per clock
// and emits floor(sum / NUM_CH). Optional BEAM_SUM_MASK_EN adds a per-channel enable mask.
module beam_sum_accumulator #(
   parameter int NUM_CH = 16,
   parameter int DATA_W = 19,
   parameter int IDX_W  = $clog2(NUM_CH),
   parameter int ACC_W  = DATA_W + IDX_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef BEAM_SUM_MASK_EN
   input  logic [NUM_CH-1:0]        ch_mask,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     busy,
   output logic [1:0]               dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
   // in_ready is registered and only high in IDLE, out_valid holds until out_ready is seen.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0] acc_shr;
   logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
   logic [DATA_W-1:0]   cap_q [NUM_CH];
   logic [DATA_W-1:0]   cur_sample;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [NUM_CH-1:0]   mask;
   logic                accept;

`ifdef BEAM_SUM_MASK_EN
   assign mask = ch_mask;
`else
   assign mask = '1;
`endif

   assign accept     = in_valid && in_ready_q;
   assign cur_sample = cap_q[ch_idx_q];
   assign acc_sum    = acc_q + {{IDX_W{cur_sample[DATA_W-1]}}, cur_sample};
   // Arithmetic shift floors toward -inf, which is the required rounding.
   assign acc_shr    = $signed(acc_sum) >>> IDX_W;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ch_idx_d    = ch_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d    = '0;
               ch_idx_d = '0;
               state_d  = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d    = acc_sum;
            ch_idx_d = ch_idx_q + 1'b1;
            if (ch_idx_q == IDX_W'(NUM_CH - 1)) begin
               out_data_d  = acc_shr[DATA_W-1:0];
               out_valid_d = 1'b1;
               state_d     = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         ch_idx_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ch_idx_q    <= ch_idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Masked-off channels are stored as zero so the accumulate path stays mask-agnostic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) cap_q[c] <= '0;
      end else if (accept) begin
         for (int c = 0; c < NUM_CH; c++)
            cap_q[c] <= mask[c] ? in_data[c*DATA_W +: DATA_W] : '0;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// Self-checking bench for beam_sum_accumulator: directed corner vectors plus randomized traffic
// checked against a floor-division reference model through an expected-value queue.
module tb_beam_sum_accumulator;

   localparam int NUM_CH = 16;
   localparam int DATA_W = 19;
   localparam int VW     = NUM_CH * DATA_W;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [VW-1:0]     in_data;
   logic [NUM_CH-1:0] in_mask;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic [1:0]        dbg_state;

   beam_sum_accumulator #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef BEAM_SUM_MASK_EN
      .ch_mask   (in_mask),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] exp_q[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                acc_edge = 0;
   int                ready_mode = 0;
   logic              prev_ov = 1'b0;
   logic              prev_rdy = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: mean of enabled channels over NUM_CH, rounded toward -inf.
   function automatic logic [DATA_W-1:0] model(input logic [VW-1:0] v,
                                               input logic [NUM_CH-1:0] m);
      int sum = 0;
      int s;
      int q;
      for (int c = 0; c < NUM_CH; c++) begin
         s = $signed(v[c*DATA_W +: DATA_W]);
         if (m[c]) sum += s;
      end
      q = sum / NUM_CH;
      if ((sum % NUM_CH != 0) && (sum < 0)) q -= 1;
      return q[DATA_W-1:0];
   endfunction

   function automatic logic [VW-1:0] fill(input int val);
      logic [VW-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(val);
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      return r;
   endfunction

   // Observes the pre-edge state, advances one clock, then drives out_ready for the next cycle.
   task automatic tick();
      logic [DATA_W-1:0] e;
      if (rst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data, in_mask));
            acc_edge = cyc + 1;
         end
         if (out_valid) begin
            check("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            check("in_ready_low", {31'd0, in_ready}, 0);
            check("busy_high", {31'd0, busy}, 1);
            if (!prev_ov) check("latency", cyc - acc_edge, NUM_CH);
            else if (!prev_rdy) check("hold_data", $signed(out_data), $signed(prev_data));
            if (out_ready && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("out_data", $signed(out_data), $signed(e));
            end
         end
         prev_ov   = out_valid;
         prev_rdy  = out_ready;
         prev_data = out_data;
      end
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   endtask

   task automatic send_vec(input logic [VW-1:0] v, input logic [NUM_CH-1:0] m);
      logic acc;
      logic done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      in_mask  = m;
      for (int n = 0; n < 200 && !done; n++) begin
         acc = in_ready;
         tick();
         done = acc;
      end
      if (!done) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = rand_vec();
      in_mask  = NUM_CH'($urandom);
   endtask

   task automatic wait_out_valid();
      for (int n = 0; n < 40 && !out_valid; n++) tick();
      check("out_valid_seen", {31'd0, out_valid}, 1);
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   logic [VW-1:0] alt;
   logic [VW-1:0] v2;

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '1;
      out_ready = 1'b0;
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", $signed(out_data), 0);
      check("rst_busy", {31'd0, busy}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      check("rel_in_ready0", {31'd0, in_ready}, 0);
      tick();
      check("rel_in_ready1", {31'd0, in_ready}, 1);

      // Constant and corner vectors with out_ready held high
      ready_mode = 0;
      tick();
      send_vec(fill(1000), '1);
      wait_out_valid();
      tick();
      check("pulse_width", {31'd0, out_valid}, 0);
      check("in_ready_after", {31'd0, in_ready}, 1);
      drain();
      send_vec(fill(262143), '1);
      drain();
      send_vec(fill(-262144), '1);
      drain();
      v2 = '0; v2[DATA_W-1:0] = DATA_W'(16);
      send_vec(v2, '1);
      drain();
      v2 = '0; v2[DATA_W-1:0] = DATA_W'(-1);
      send_vec(v2, '1);
      drain();
      for (int c = 0; c < NUM_CH; c++) alt[c*DATA_W +: DATA_W] = DATA_W'((c % 2 == 0) ? 100 : -100);
      send_vec(alt, '1);
      drain();

      // Backpressure: second vector is presented while the first result is stalled
      ready_mode = 2;
      out_ready  = 1'b0;
      send_vec(rand_vec(), '1);
      wait_out_valid();
      v2       = rand_vec();
      in_valid = 1'b1;
      in_data  = v2;
      in_mask  = '1;
      for (int n = 0; n < 10; n++) begin
         tick();
         check("bp_in_ready", {31'd0, in_ready}, 0);
         check("bp_out_valid", {31'd0, out_valid}, 1);
      end
      ready_mode = 0;
      out_ready  = 1'b1;
      tick();
      check("bp_in_ready_next", {31'd0, in_ready}, 1);
      check("bp_busy_next", {31'd0, busy}, 0);
      send_vec(v2, '1);
      drain();

      // Reset in the middle of accumulation
      send_vec(rand_vec(), '1);
      repeat (7) tick();
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 0);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_out_data", $signed(out_data), 0);
      exp_q.delete();
      prev_ov = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      check("mid_rel_in_ready0", {31'd0, in_ready}, 0);
      tick();
      check("mid_rel_in_ready1", {31'd0, in_ready}, 1);
      repeat (20) tick();
      check("no_out_after_rst", {31'd0, out_valid}, 0);
      send_vec(fill(5), '1);
      drain();

`ifdef BEAM_SUM_MASK_EN
      send_vec(fill(1600), 16'h00FF);
      drain();
      send_vec(fill(1600), 16'h0000);
      drain();
`endif

      // Randomized traffic with random backpressure and idle gaps
      ready_mode = 1;
      for (int k = 0; k < 40; k++) begin
`ifdef BEAM_SUM_MASK_EN
         send_vec(rand_vec(), NUM_CH'($urandom));
`else
         send_vec(rand_vec(), '1);
`endif
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();
      ready_mode = 0;
      repeat (25) tick();
      check("idle_at_end", {31'd0, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
